// File: rtl/hidden_cpu_ctrl_if.sv
// Instruction-beat handshake between the pin interface (master) and the CPU control unit (slave).
// A beat moves when instr_valid and instr_ready are both high on a rising clock edge.
interface hidden_cpu_ctrl_if;
  logic       instr_valid;
  logic [5:0] instr;
  logic       instr_ready;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/hidden_cpu_ctrl.sv
// Control unit for the 4 x 8-bit register CPU: decodes {op, rd, rs} beats, assembles LDI
// immediates from two nibble payload beats, sequences register/flag writes and counts retired instructions.
module hidden_cpu_ctrl #(
  parameter int DATA_W = 8,
  parameter int NIB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  hidden_cpu_ctrl_if.slave  bus,
  output logic [1:0]        rf_raddr_a_o,
  output logic [1:0]        rf_raddr_b_o,
  output logic [1:0]        rf_waddr_o,
  output logic              rf_we_o,
  output logic              wb_sel_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [1:0]        alu_op_o,
  output logic              flag_we_o,
  output logic [DATA_W-1:0] pc_o,
  output logic              halted_o
);

  localparam logic [1:0] OP_EXT   = 2'b11;
  localparam logic [1:0] EXT_LDI  = 2'b00;
  localparam logic [1:0] EXT_HALT = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_WB     = 3'd2,
    S_IMM_HI = 3'd3,
    S_IMM_LO = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t             state_q;
  logic [5:0]         ir_q;
  logic               ready_q;
  logic [1:0]         raddr_a_q;
  logic [1:0]         raddr_b_q;
  logic [1:0]         waddr_q;
  logic               rf_we_q;
  logic               wb_sel_q;
  logic [DATA_W-1:0]  imm_q;
  logic [1:0]         alu_op_q;
  logic               flag_we_q;
  logic [DATA_W-1:0]  pc_q;
  logic               halted_q;

  logic               accept;
  logic [1:0]         hdr_op;
  logic [1:0]         hdr_rd;
  logic [1:0]         hdr_rs;
  logic [DATA_W-1:0]  pc_d;

  function automatic logic writes_rf(input logic [5:0] ir);
    return ir[5:4] != OP_EXT;
  endfunction

  // Only ADD (00) and SUB (01) produce a carry/borrow worth latching.
  function automatic logic sets_flag(input logic [5:0] ir);
    return ir[5] == 1'b0;
  endfunction

  function automatic logic [1:0] alu_of(input logic [1:0] op);
    return (op == OP_EXT) ? ALU_ADD : op;
  endfunction

  always_comb begin
    accept = bus.instr_valid && ready_q;
    hdr_op = bus.instr[5:4];
    hdr_rd = bus.instr[3:2];
    hdr_rs = bus.instr[1:0];
    pc_d   = pc_q + DATA_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= 6'd0;
      ready_q   <= 1'b1;
      raddr_a_q <= 2'd0;
      raddr_b_q <= 2'd0;
      waddr_q   <= 2'd0;
      rf_we_q   <= 1'b0;
      wb_sel_q  <= 1'b0;
      imm_q     <= '0;
      alu_op_q  <= 2'd0;
      flag_we_q <= 1'b0;
      pc_q      <= '0;
      halted_q  <= 1'b0;
    end else begin
      rf_we_q   <= 1'b0;
      flag_we_q <= 1'b0;
      wb_sel_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ir_q      <= bus.instr;
            raddr_a_q <= hdr_rd;
            raddr_b_q <= hdr_rs;
            waddr_q   <= hdr_rd;
            alu_op_q  <= alu_of(hdr_op);
            if (hdr_op != OP_EXT) begin
              state_q <= S_EXEC;
              ready_q <= 1'b0;
            end else begin
              case (hdr_rs)
                EXT_LDI:  state_q <= S_IMM_HI;
                EXT_HALT: begin
                  state_q  <= S_HALT;
                  ready_q  <= 1'b0;
                  halted_q <= 1'b1;
                end
                default: begin
                  state_q <= S_EXEC;
                  ready_q <= 1'b0;
                end
              endcase
            end
          end
        end
        S_EXEC: begin
          state_q   <= S_WB;
          waddr_q   <= ir_q[3:2];
          rf_we_q   <= writes_rf(ir_q);
          flag_we_q <= writes_rf(ir_q) && sets_flag(ir_q);
          pc_q      <= pc_d;
        end
        S_WB: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        // Payload beats carry data only; their top bits are never decoded.
        S_IMM_HI: begin
          if (accept) begin
            imm_q[DATA_W-1:NIB_W] <= bus.instr[NIB_W-1:0];
            state_q               <= S_IMM_LO;
          end
        end
        S_IMM_LO: begin
          if (accept) begin
            imm_q[NIB_W-1:0] <= bus.instr[NIB_W-1:0];
            state_q          <= S_WB;
            ready_q          <= 1'b0;
            rf_we_q          <= 1'b1;
            wb_sel_q         <= 1'b1;
            pc_q             <= pc_d;
          end
        end
        S_HALT: begin
          ready_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign rf_raddr_a_o    = raddr_a_q;
  assign rf_raddr_b_o    = raddr_b_q;
  assign rf_waddr_o      = waddr_q;
  assign rf_we_o         = rf_we_q;
  assign wb_sel_o        = wb_sel_q;
  assign imm_o           = imm_q;
  assign alu_op_o        = alu_op_q;
  assign flag_we_o       = flag_we_q;
  assign pc_o            = pc_q;
  assign halted_o        = halted_q;

endmodule
